// File: rtl/spi_reg_pkg.sv
// Shared constants and state type for the SPI register bridge.
package spi_reg_pkg;

  localparam int DEF_ADDR_W      = 7;
  localparam int DEF_BYTE_CNT_W  = 8;
  localparam int CMD_RD_BIT      = 7;
  localparam logic [7:0] DEF_IDLE_RESP = 8'hA5;

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_WR     = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_CAP = 3'd3,
    S_RD     = 3'd4
  } state_t;

endpackage

// File: rtl/cs_sync_edge.sv
// Chip-select synchronizer with rise/fall pulse outputs.
// All stages reset to 1 so a frame already in progress at reset release
// is seen as a fresh falling edge.
module cs_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  output logic rise,
  output logic fall
);

  logic sync_q1, sync_q2, prev_q;

  // two-stage synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync_q1 <= cs_n;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~prev_q;
  assign fall = ~sync_q2 & prev_q;

endmodule

// File: rtl/spi_slave_reg_bridge.sv
// Turns the SPI driver's received byte stream into burst register accesses.
// First byte of a frame is the command (bit7 = read, bits[6:0] = start address).
//
// state    | meaning
// S_CMD    | waiting for command byte
// S_WR     | each received byte becomes a write, address auto-increments
// S_RD_REQ | read strobe issued at reg_addr
// S_RD_CAP | read data captured into response_data
// S_RD     | waiting for next byte slot, then prefetch next address
module spi_slave_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter logic [7:0] IDLE_RESP  = DEF_IDLE_RESP,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter int         BYTE_CNT_W = DEF_BYTE_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rec_data,
  input  logic                  rec_done,
  input  logic                  cs_n,
  output logic [7:0]            response_data,
  output logic [ADDR_W-1:0]     reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [7:0]            reg_rdata,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic [BYTE_CNT_W-1:0] byte_cnt
);

  localparam logic [ADDR_W-1:0]     ADDR_ONE = ADDR_W'(1);
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE  = BYTE_CNT_W'(1);
  localparam logic [BYTE_CNT_W-1:0] CNT_MAX  = '1;

  state_t state, state_nx;
  logic   cs_rise, cs_fall;
  logic   byte_valid;
  logic   is_rd_cmd;

  cs_sync_edge u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .cs_n  (cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // bytes arriving outside a frame are stray and ignored everywhere
  assign byte_valid = rec_done & frame_active;
  assign is_rd_cmd  = rec_data[CMD_RD_BIT];

  // frame tracking and saturating byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      byte_cnt     <= '0;
    end else begin
      frame_done <= cs_rise;
      if (cs_fall) begin
        frame_active <= 1'b1;
        byte_cnt     <= '0;
      end else begin
        if (cs_rise)
          frame_active <= 1'b0;
        if (byte_valid && byte_cnt != CNT_MAX)
          byte_cnt <= byte_cnt + CNT_ONE;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_CMD;
    else
      state <= state_nx;
  end

  // next state and read strobe; frame end always returns to command decode
  always_comb begin
    state_nx  = state;
    reg_rd_en = 1'b0;
    case (state)
      S_CMD:    if (byte_valid) state_nx = is_rd_cmd ? S_RD_REQ : S_WR;
      S_WR:     state_nx = S_WR;
      S_RD_REQ: begin
        reg_rd_en = 1'b1;
        state_nx  = S_RD_CAP;
      end
      S_RD_CAP: state_nx = S_RD;
      S_RD:     if (byte_valid) state_nx = S_RD_REQ;
      default:  state_nx = S_CMD;
    endcase
    if (cs_rise)
      state_nx = S_CMD;
  end

  // register bus address/data and MISO response byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wr_en     <= 1'b0;
      response_data <= IDLE_RESP;
    end else begin
      reg_wr_en <= 1'b0;
      // address advances the cycle after each write strobe
      if (reg_wr_en)
        reg_addr <= reg_addr + ADDR_ONE;
      if (byte_valid) begin
        case (state)
          S_CMD: reg_addr <= rec_data[ADDR_W-1:0];
          S_WR: begin
            reg_wr_en <= 1'b1;
            reg_wdata <= rec_data;
          end
          S_RD:  reg_addr <= reg_addr + ADDR_ONE;
          default: ;
        endcase
      end
      if (state == S_RD_CAP)
        response_data <= reg_rdata;
      // an aborted read must not leak its data into the next frame
      if (cs_rise)
        response_data <= IDLE_RESP;
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Self-checking bench: table-driven frames, hand-written corner sequences,
// and random frames checked against a byte-stream level register model.
module tb_spi_slave_reg_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rec_data;
  logic       rec_done;
  logic       cs_n;
  logic [7:0] response_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata = 8'h00;
  logic       frame_active;
  logic       frame_done;
  logic [7:0] byte_cnt;

  spi_slave_reg_bridge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rec_data      (rec_data),
    .rec_done      (rec_done),
    .cs_n          (cs_n),
    .response_data (response_data),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wr_en     (reg_wr_en),
    .reg_rd_en     (reg_rd_en),
    .reg_rdata     (reg_rdata),
    .frame_active  (frame_active),
    .frame_done    (frame_done),
    .byte_cnt      (byte_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // register file attached to the bus, plus a passive strobe monitor
  logic [7:0] mem [128];
  logic [7:0] exp_mem [128];
  logic       load_mem;
  int         wr_a[$], wr_d[$], rd_a[$];
  int         fd_cnt = 0;
  int         conflict = 0;
  int         wr_mark, rd_mark, fd_mark;

  function automatic logic [7:0] preload(input int i);
    case (i)
      16'h10:  return 8'h3C;
      16'h11:  return 8'hC3;
      16'h12:  return 8'h5A;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // bus slave: writes land at the edge, read data valid one clk after strobe
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= preload(i);
    end else begin
      if (reg_wr_en) mem[reg_addr] <= reg_wdata;
      if (reg_rd_en) reg_rdata <= mem[reg_addr];
    end
  end

  // strobe and frame_done logging
  always @(posedge clk) begin
    if (reg_wr_en) begin
      wr_a.push_back(int'(reg_addr));
      wr_d.push_back(int'(reg_wdata));
    end
    if (reg_rd_en) rd_a.push_back(int'(reg_addr));
    if (frame_done) fd_cnt++;
    if (reg_wr_en && reg_rd_en) conflict++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic begin_frame();
    wr_mark = wr_a.size();
    rd_mark = rd_a.size();
    fd_mark = fd_cnt;
    cs_n = 1'b0;
    for (int i = 0; i < 10 && !frame_active; i++) tick();
    check("frame_start", frame_active, 1);
    check("cnt_clear", byte_cnt, 0);
  endtask

  // one byte slot; response checked exactly 3 clk after rec_done
  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_resp);
    rec_data = b;
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    tick();
    tick();
    check("resp", response_data, exp_resp);
    repeat (1 + $urandom_range(0, 2)) tick();
  endtask

  task automatic end_frame(input int exp_cnt);
    cs_n = 1'b1;
    for (int i = 0; i < 10 && fd_cnt == fd_mark; i++) tick();
    tick();
    tick();
    check("frame_done_cnt", fd_cnt - fd_mark, 1);
    check("end_active", frame_active, 0);
    check("end_resp", response_data, 8'hA5);
    check("byte_cnt", byte_cnt, exp_cnt);
  endtask

  // reference: a write frame writes bytes 1..n-1 at a0, a0+1, ... (mod 128);
  // a read frame reads a0 .. a0+n-1 (mod 128)
  task automatic check_bus(input logic [7:0] q[$]);
    int a, n, ea, idx;
    a = int'(q[0][6:0]);
    n = q.size();
    if (!q[0][7]) begin
      check("wr_count", wr_a.size() - wr_mark, n - 1);
      for (int i = 1; i < n; i++) begin
        ea  = (a + i - 1) % 128;
        idx = wr_mark + i - 1;
        if (idx < wr_a.size()) begin
          check("wr_addr", wr_a[idx], ea);
          check("wr_data", wr_d[idx], q[i]);
        end
        exp_mem[ea] = q[i];
      end
    end else begin
      check("rd_count", rd_a.size() - rd_mark, n);
      for (int k = 0; k < n; k++) begin
        idx = rd_mark + k;
        if (idx < rd_a.size()) check("rd_addr", rd_a[idx], (a + k) % 128);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] q[$]);
    int a;
    logic [7:0] er;
    a = int'(q[0][6:0]);
    begin_frame();
    for (int k = 0; k < q.size(); k++) begin
      er = q[0][7] ? exp_mem[(a + k) % 128] : 8'hA5;
      send_byte(q[k], er);
    end
    end_frame(q.size() > 255 ? 255 : q.size());
    check_bus(q);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b    [4];
    logic [7:0] resp [4];
    int         cnt;
  } vec_t;

  vec_t vt [4];
  logic [7:0] q[$];
  int cnt_before;

  initial begin
    vt[0].n = 3; vt[0].b = '{8'h05, 8'h11, 8'h22, 8'h00}; vt[0].resp = '{8'hA5, 8'hA5, 8'hA5, 8'hA5}; vt[0].cnt = 3;
    vt[1].n = 3; vt[1].b = '{8'h90, 8'h00, 8'h00, 8'h00}; vt[1].resp = '{8'h3C, 8'hC3, 8'h5A, 8'hA5}; vt[1].cnt = 3;
    vt[2].n = 3; vt[2].b = '{8'h7F, 8'hAA, 8'hBB, 8'h00}; vt[2].resp = '{8'hA5, 8'hA5, 8'hA5, 8'hA5}; vt[2].cnt = 3;
    vt[3].n = 2; vt[3].b = '{8'hFF, 8'h00, 8'h00, 8'h00}; vt[3].resp = '{8'hAA, 8'hBB, 8'hA5, 8'hA5}; vt[3].cnt = 2;

    cs_n = 1'b1; rec_done = 1'b0; rec_data = 8'h00; rst_n = 1'b0; load_mem = 1'b1;
    for (int i = 0; i < 128; i++) exp_mem[i] = preload(i);
    repeat (3) tick();
    load_mem = 1'b0;

    check("rst_resp", response_data, 8'hA5);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_rd_en", reg_rd_en, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", byte_cnt, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      q = {};
      for (int k = 0; k < vt[v].n; k++) q.push_back(vt[v].b[k]);
      begin_frame();
      for (int k = 0; k < vt[v].n; k++) send_byte(vt[v].b[k], vt[v].resp[k]);
      end_frame(vt[v].cnt);
      check_bus(q);
      repeat (3) tick();
    end

    // last byte coincides with the synchronized cs_n rise
    begin_frame();
    send_byte(8'h50, 8'hA5);
    send_byte(8'h12, 8'hA5);
    cs_n = 1'b1;
    tick();
    tick();
    rec_data = 8'h34;
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    repeat (4) tick();
    check("coinc_done", fd_cnt - fd_mark, 1);
    check("coinc_cnt", byte_cnt, 3);
    check("coinc_active", frame_active, 0);
    q = {8'h50, 8'h12, 8'h34};
    check_bus(q);
    repeat (3) tick();

    // early abort of a read, then a fresh command in the next frame
    begin_frame();
    rec_data = 8'h80;
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    cs_n = 1'b1;
    repeat (6) tick();
    check("abort_resp", response_data, 8'hA5);
    check("abort_active", frame_active, 0);
    check("abort_done", fd_cnt - fd_mark, 1);
    repeat (3) tick();
    q = {8'h20, 8'h77};
    run_frame(q);
    repeat (3) tick();

    // stray byte with cs_n high
    wr_mark = wr_a.size();
    rd_mark = rd_a.size();
    cnt_before = int'(byte_cnt);
    rec_data = 8'h81;
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    repeat (5) tick();
    check("stray_wr", wr_a.size() - wr_mark, 0);
    check("stray_rd", rd_a.size() - rd_mark, 0);
    check("stray_cnt", byte_cnt, cnt_before);

    // byte counter saturation on a long write burst
    q = {8'h40};
    for (int i = 0; i < 259; i++) q.push_back(8'($urandom));
    run_frame(q);
    repeat (3) tick();

    // random frames against the model
    for (int f = 0; f < 20; f++) begin
      q = {8'($urandom)};
      for (int i = $urandom_range(0, 4); i > 0; i--) q.push_back(8'($urandom));
      run_frame(q);
      repeat ($urandom_range(2, 5)) tick();
    end

    // asynchronous reset with a write strobe pending
    begin_frame();
    send_byte(8'h30, 8'hA5);
    rec_data = 8'h44;
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_resp", response_data, 8'hA5);
    check("arst_addr", reg_addr, 0);
    check("arst_wdata", reg_wdata, 0);
    check("arst_wr_en", reg_wr_en, 0);
    check("arst_rd_en", reg_rd_en, 0);
    check("arst_active", frame_active, 0);
    check("arst_done", frame_done, 0);
    check("arst_cnt", byte_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    begin_frame();
    send_byte(8'h55, 8'hA5);
    check("arst_no_wr", wr_a.size() - wr_mark, 0);
    send_byte(8'h66, 8'hA5);
    end_frame(2);
    q = {8'h55, 8'h66};
    check_bus(q);

    check("strobe_excl", conflict, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
